// File: rtl/dma_controller_if.sv
// Bus bundle between the DMA engine and its CPU / device / memory-port-2 neighbours.
// master = DMA engine side, slave = CPU, device and memory side.
interface dma_controller_if #(
    parameter int WORD_SIZE  = 16,
    parameter int BLOCK_SIZE = 64
);
    // CPU command
    logic                  cmd_valid;
    logic [WORD_SIZE-1:0]  cmd_address;
    logic [WORD_SIZE-1:0]  cmd_length;
    // bus arbitration and completion
    logic                  BG;
    logic                  BR;
    logic                  dma_end_interrupt;
    logic                  dma_busy;
    // device block fetch
    logic [WORD_SIZE-1:0]  dev_index;
    logic [BLOCK_SIZE-1:0] dev_data;
    // memory port-2 write path
    logic                  M2busy;
    logic                  dma_writeM2;
    logic [WORD_SIZE-1:0]  dma_address2;
    logic [BLOCK_SIZE-1:0] dma_data2;

    modport master (
        input  cmd_valid, cmd_address, cmd_length, BG, dev_data, M2busy,
        output BR, dev_index, dma_writeM2, dma_address2, dma_data2,
               dma_end_interrupt, dma_busy
    );

    modport slave (
        output cmd_valid, cmd_address, cmd_length, BG, dev_data, M2busy,
        input  BR, dev_index, dma_writeM2, dma_address2, dma_data2,
               dma_end_interrupt, dma_busy
    );
endinterface

// File: rtl/dma_controller.sv
// Bus-master DMA engine: requests the bus with BR, waits for BG, then copies
// device blocks into data memory through the port-2 write path, one block per
// write, and signals completion with a one-cycle dma_end_interrupt.
// Every output is a register; the FSM computes the next output values from the
// next state so that outputs line up with the state they belong to.
module dma_controller #(
    parameter int WORD_SIZE   = 16,
    parameter int BLOCK_WORDS = 4,    // power of two, >= 2
    parameter int BLOCK_SIZE  = WORD_SIZE * BLOCK_WORDS
) (
    input  logic               Clk,
    input  logic               Reset_N,
    dma_controller_if.master   bus
);
    localparam int LOG2_BW = $clog2(BLOCK_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [WORD_SIZE-1:0]  base_q, base_d;
    logic [WORD_SIZE-1:0]  blocks_q, blocks_d;
    logic [WORD_SIZE-1:0]  idx_q, idx_d;
    logic [WORD_SIZE-1:0]  dev_idx_q, dev_idx_d;
    logic [WORD_SIZE-1:0]  addr_q, addr_d;
    logic [BLOCK_SIZE-1:0] data_q, data_d;
    logic                  br_q, br_d;
    logic                  wr_q, wr_d;
    logic                  int_q, int_d;
    logic                  busy_q, busy_d;

    // ceil(cmd_length / BLOCK_WORDS): a partial tail still costs a full block
    logic [WORD_SIZE-1:0]  cmd_blocks;
    logic [WORD_SIZE-1:0]  idx_inc;

    assign cmd_blocks = (bus.cmd_length >> LOG2_BW)
                      + WORD_SIZE'(|bus.cmd_length[LOG2_BW-1:0]);
    assign idx_inc    = idx_q + 1'b1;

    // Next state, transfer bookkeeping and next values of the registered outputs
    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        blocks_d  = blocks_q;
        idx_d     = idx_q;
        dev_idx_d = dev_idx_q;
        addr_d    = addr_q;
        data_d    = data_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    base_d    = bus.cmd_address;
                    blocks_d  = cmd_blocks;
                    idx_d     = '0;
                    dev_idx_d = '0;
                    state_d   = (cmd_blocks == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // dev_index already points at idx, so dev_data is the block to write
                if (bus.BG) begin
                    addr_d  = base_q + (idx_q << LOG2_BW);
                    data_d  = bus.dev_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Point the device at the next block while memory is busy, so its
                // data is ready on the completion edge. Stay put after the last one.
                if (idx_inc != blocks_q)
                    dev_idx_d = idx_inc;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!bus.M2busy) begin
                    idx_d = idx_inc;
                    if (idx_inc == blocks_q) begin
                        state_d = S_DONE;
                    end else if (bus.BG) begin
                        addr_d  = base_q + (idx_inc << LOG2_BW);
                        data_d  = bus.dev_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        br_d   = (state_d == S_REQ) || (state_d == S_WRITE) || (state_d == S_WAIT);
        wr_d   = (state_d == S_WRITE);
        // pulse lands the cycle after DONE, when BR is already low
        int_d  = (state_q == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers, synchronous active-low reset from any state
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            blocks_q  <= '0;
            idx_q     <= '0;
            dev_idx_q <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            br_q      <= 1'b0;
            wr_q      <= 1'b0;
            int_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            blocks_q  <= blocks_d;
            idx_q     <= idx_d;
            dev_idx_q <= dev_idx_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            br_q      <= br_d;
            wr_q      <= wr_d;
            int_q     <= int_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.BR                = br_q;
    assign bus.dev_index         = dev_idx_q;
    assign bus.dma_writeM2       = wr_q;
    assign bus.dma_address2      = addr_q;
    assign bus.dma_data2         = data_q;
    assign bus.dma_end_interrupt = int_q;
    assign bus.dma_busy          = busy_q;
endmodule

// File: tb/tb_dma_controller.sv
// Directed bench for dma_controller: a device model, a memory port-2 model with
// fixed busy latency, a write/interrupt logger, and one linear stimulus sequence.
module tb_dma_controller;
    localparam int WS      = 16;
    localparam int BW      = 4;
    localparam int BS      = 64;
    localparam int MEM_LAT = 4;

    logic Clk     = 1'b0;
    logic Reset_N = 1'b0;

    dma_controller_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) bus ();

    dma_controller #(.WORD_SIZE(WS), .BLOCK_WORDS(BW), .BLOCK_SIZE(BS)) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // device: distinct 64-bit pattern per block index
    function automatic logic [63:0] dev_model(input logic [15:0] i);
        return {i ^ 16'ha5a5, i + 16'h1234, ~i, i};
    endfunction
    assign bus.dev_data = dev_model(bus.dev_index);

    // memory: busy for MEM_LAT cycles starting the cycle after a write
    int busy_cnt = 0;
    always @(posedge Clk) begin
        if (!Reset_N)             busy_cnt <= 0;
        else if (bus.dma_writeM2) busy_cnt <= MEM_LAT;
        else if (busy_cnt > 0)    busy_cnt <= busy_cnt - 1;
    end
    assign bus.M2busy = (busy_cnt > 0);

    // logger, sampled mid-cycle
    logic [15:0] wr_addr [64];
    logic [63:0] wr_data [64];
    logic [15:0] wr_idx  [64];
    int          wr_cyc  [64];
    int          n_wr = 0, n_int = 0, n_br = 0, int_cyc = 0;
    logic        br_at_int = 1'b0;
    always @(negedge Clk) begin
        if (bus.dma_writeM2 && n_wr < 64) begin
            wr_addr[n_wr] <= bus.dma_address2;
            wr_data[n_wr] <= bus.dma_data2;
            wr_idx[n_wr]  <= bus.dev_index;
            wr_cyc[n_wr]  <= cyc;
            n_wr          <= n_wr + 1;
        end
        if (bus.dma_end_interrupt) begin
            n_int     <= n_int + 1;
            int_cyc   <= cyc;
            br_at_int <= bus.BR;
        end
        if (bus.BR) n_br <= n_br + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        @(negedge Clk);
        #1;
    endtask

    // cmd_valid is high for the one cycle returned in c
    task automatic send_cmd(input logic [15:0] a, input logic [15:0] l, output int c);
        drive_edge();
        bus.cmd_valid   = 1'b1;
        bus.cmd_address = a;
        bus.cmd_length  = l;
        c               = cyc;
        drive_edge();
        bus.cmd_valid   = 1'b0;
    endtask

    task automatic wait_int(input int target, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (n_int >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int target, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (n_wr >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_br(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (bus.BR) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   c, bg_cyc, bw, bi, bb, br_low;
        logic ok;
        logic [15:0] t1_addr [3];
        t1_addr = '{16'h00f0, 16'h00f4, 16'h00f8};

        bus.cmd_valid   = 1'b0;
        bus.cmd_address = '0;
        bus.cmd_length  = '0;
        bus.BG          = 1'b0;

        // reset state
        repeat (3) drive_edge();
        tick();
        chk("rst BR",    bus.BR, 0);
        chk("rst wr",    bus.dma_writeM2, 0);
        chk("rst int",   bus.dma_end_interrupt, 0);
        chk("rst busy",  bus.dma_busy, 0);
        chk("rst addr",  bus.dma_address2, 0);
        chk("rst data",  bus.dma_data2, 0);
        chk("rst index", bus.dev_index, 0);
        drive_edge();
        Reset_N = 1'b1;

        // 1: 12 words at 0x00f0, BG one cycle after BR
        bw = n_wr; bi = n_int;
        send_cmd(16'h00f0, 16'd12, c);
        tick();
        chk("t1 busy", bus.dma_busy, 1);
        chk("t1 BR",   bus.BR, 1);
        drive_edge();
        bus.BG = 1'b1;
        bg_cyc = cyc;
        wait_int(bi + 1, ok);
        chk("t1 int seen", ok, 1);
        chk("t1 nwr", n_wr - bw, 3);
        for (int j = 0; j < 3; j++) begin
            chk("t1 addr", wr_addr[bw + j], t1_addr[j]);
            chk("t1 idx",  wr_idx[bw + j], j);
            chk("t1 data", wr_data[bw + j], dev_model(16'(j)));
        end
        chk("t1 first wr cycle", wr_cyc[bw], bg_cyc + 1);
        chk("t1 wr spacing", wr_cyc[bw + 1] - wr_cyc[bw], 6);
        chk("t1 int cycle", int_cyc, wr_cyc[bw + 2] + 7);
        chk("t1 BR at int", br_at_int, 0);
        drive_edge();
        bus.BG = 1'b0;
        tick();
        chk("t1 busy after", bus.dma_busy, 0);
        chk("t1 int count", n_int - bi, 1);

        // 2: BG withheld 10 cycles
        bw = n_wr; bi = n_int;
        send_cmd(16'h0100, 16'd4, c);
        wait_br(ok);
        chk("t2 BR seen", ok, 1);
        br_low = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (!bus.BR) br_low++;
        end
        chk("t2 BR held", br_low, 0);
        chk("t2 no wr before BG", n_wr - bw, 0);
        drive_edge();
        bus.BG = 1'b1;
        bg_cyc = cyc;
        wait_int(bi + 1, ok);
        chk("t2 int seen", ok, 1);
        chk("t2 nwr", n_wr - bw, 1);
        chk("t2 wr cycle", wr_cyc[bw], bg_cyc + 1);
        chk("t2 addr", wr_addr[bw], 16'h0100);
        drive_edge();
        bus.BG = 1'b0;

        // 3: BG dropped during block 0's WAIT
        bw = n_wr; bi = n_int;
        send_cmd(16'h00f0, 16'd8, c);
        drive_edge();
        bus.BG = 1'b1;
        wait_wr(bw + 1, ok);
        chk("t3 wr0 seen", ok, 1);
        drive_edge();
        bus.BG = 1'b0;
        repeat (10) tick();
        chk("t3 BR re-req", bus.BR, 1);
        chk("t3 held at 1 wr", n_wr - bw, 1);
        chk("t3 no int yet", n_int - bi, 0);
        drive_edge();
        bus.BG = 1'b1;
        bg_cyc = cyc;
        wait_int(bi + 1, ok);
        chk("t3 int seen", ok, 1);
        chk("t3 nwr", n_wr - bw, 2);
        chk("t3 addr1", wr_addr[bw + 1], 16'h00f4);
        chk("t3 idx1",  wr_idx[bw + 1], 1);
        chk("t3 data1", wr_data[bw + 1], dev_model(16'd1));
        chk("t3 wr1 cycle", wr_cyc[bw + 1], bg_cyc + 1);
        drive_edge();
        bus.BG = 1'b0;

        // 4: zero length
        bw = n_wr; bi = n_int; bb = n_br;
        send_cmd(16'h00f0, 16'd0, c);
        wait_int(bi + 1, ok);
        chk("t4 int seen", ok, 1);
        chk("t4 int cycle", int_cyc, c + 2);
        chk("t4 no BR", n_br - bb, 0);
        chk("t4 no wr", n_wr - bw, 0);

        // 5: reset during WAIT, then a fresh command
        send_cmd(16'h00f0, 16'd8, c);
        bw = n_wr;
        drive_edge();
        bus.BG = 1'b1;
        wait_wr(bw + 1, ok);
        chk("t5 wr0 seen", ok, 1);
        drive_edge();
        drive_edge();
        Reset_N = 1'b0;
        bus.BG  = 1'b0;
        drive_edge();
        tick();
        chk("t5 rst BR",    bus.BR, 0);
        chk("t5 rst wr",    bus.dma_writeM2, 0);
        chk("t5 rst int",   bus.dma_end_interrupt, 0);
        chk("t5 rst busy",  bus.dma_busy, 0);
        chk("t5 rst addr",  bus.dma_address2, 0);
        chk("t5 rst data",  bus.dma_data2, 0);
        chk("t5 rst index", bus.dev_index, 0);
        drive_edge();
        Reset_N = 1'b1;
        bw = n_wr; bi = n_int;
        send_cmd(16'h0040, 16'd4, c);
        drive_edge();
        bus.BG = 1'b1;
        wait_int(bi + 1, ok);
        chk("t5 int seen", ok, 1);
        chk("t5 nwr", n_wr - bw, 1);
        chk("t5 addr", wr_addr[bw], 16'h0040);
        chk("t5 data", wr_data[bw], dev_model(16'd0));
        drive_edge();
        bus.BG = 1'b0;

        // 6: address wrap, partial tail block, ignored second command
        bw = n_wr; bi = n_int;
        send_cmd(16'hfffc, 16'd5, c);
        drive_edge();
        bus.BG = 1'b1;
        wait_wr(bw + 1, ok);
        chk("t6 wr0 seen", ok, 1);
        send_cmd(16'h1234, 16'd16, c);
        wait_int(bi + 1, ok);
        chk("t6 int seen", ok, 1);
        repeat (30) tick();
        chk("t6 nwr", n_wr - bw, 2);
        chk("t6 addr0", wr_addr[bw], 16'hfffc);
        chk("t6 addr1", wr_addr[bw + 1], 16'h0000);
        chk("t6 idx1",  wr_idx[bw + 1], 1);
        chk("t6 data1", wr_data[bw + 1], dev_model(16'd1));
        chk("t6 one int", n_int - bi, 1);
        chk("t6 idle", bus.dma_busy, 0);
        drive_edge();
        bus.BG = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
